// File: rtl/fc1_weight_fifo.sv
// Weight-group FIFO feeding fc1: a registered head word plus a circular RAM,
// with (row, group) position tracking, an end-of-matrix pulse and sticky error flags.
module fc1_weight_fifo #(
    parameter int NUM_PE         = 4,
    parameter int DEPTH          = 16,
    parameter int GROUPS_PER_ROW = 33,
    parameter int ROWS           = 10
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    clear,
    input  logic                                                    wr_en,
    input  logic [31:0]                                             wr_data,
    output logic                                                    wr_ready,
    input  logic                                                    fc1_next,
    output logic [NUM_PE*8-1:0]                                     w_out,
    output logic                                                    w_valid,
    output logic [$clog2(DEPTH+1)-1:0]                              level,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]              row_idx,
    output logic [((GROUPS_PER_ROW > 1) ? $clog2(GROUPS_PER_ROW) : 1)-1:0] grp_idx,
    output logic                                                    done,
    output logic                                                    overflow,
    output logic                                                    underflow,
    input  logic                                                    err_clr
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int RAM_D = DEPTH - 1;
    localparam int PTR_W = (RAM_D > 1) ? $clog2(RAM_D) : 1;
    localparam int CNT_W = $clog2(DEPTH);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GRP_W = (GROUPS_PER_ROW > 1) ? $clog2(GROUPS_PER_ROW) : 1;

    localparam logic [LVL_W-1:0] DEPTH_L    = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAM_D - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [GRP_W-1:0] GRP_LAST   = GRP_W'(GROUPS_PER_ROW - 1);

    generate
        if (NUM_PE * 8 != 32) begin : g_bad_num_pe
            $error("fc1_weight_fifo: NUM_PE*8 must equal 32");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("fc1_weight_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [31:0]      mem [0:RAM_D-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] ram_cnt;

    logic full;
    logic ram_empty;
    logic pop;
    logic push;
    logic head_from_ram;
    logic head_from_in;
    logic ram_wr;
    logic grp_wrap;
    logic last_grp;
    logic ovf_evt;
    logic udf_evt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full          = (level == DEPTH_L);
        ram_empty     = (ram_cnt == '0);
        pop           = fc1_next & w_valid;
        push          = wr_en & (~full | pop) & ~clear;
        head_from_ram = pop & ~ram_empty;
        // A word bypasses the RAM whenever the head would otherwise be empty.
        head_from_in  = push & (~w_valid | (pop & ram_empty));
        ram_wr        = push & ~head_from_in;
        grp_wrap      = pop & (grp_idx == GRP_LAST);
        last_grp      = grp_wrap & (row_idx == ROW_LAST);
        ovf_evt       = wr_en & full & ~pop;
        udf_evt       = fc1_next & ~w_valid;
    end

    assign wr_ready = ~full;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_out   <= '0;
            w_valid <= 1'b0;
            level   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            row_idx <= '0;
            grp_idx <= '0;
            done    <= 1'b0;
        end else if (clear) begin
            w_out   <= '0;
            w_valid <= 1'b0;
            level   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            row_idx <= '0;
            grp_idx <= '0;
            done    <= 1'b0;
        end else begin
            done <= last_grp;

            if (head_from_ram) begin
                w_out  <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end else if (head_from_in) begin
                w_out <= wr_data;
            end

            if (head_from_ram | head_from_in) begin
                w_valid <= 1'b1;
            end else if (pop) begin
                w_valid <= 1'b0;
            end

            if (ram_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end

            ram_cnt <= ram_cnt + CNT_W'(ram_wr) - CNT_W'(head_from_ram);

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (pop) begin
                if (grp_wrap) begin
                    grp_idx <= '0;
                    row_idx <= last_grp ? '0 : row_idx + ROW_W'(1);
                end else begin
                    grp_idx <= grp_idx + GRP_W'(1);
                end
            end
        end
    end

    // Error flags survive clear; a new event in the err_clr cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt | (overflow & ~err_clr);
            underflow <= udf_evt | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fc1_weight_fifo.sv
// Directed bench for fc1_weight_fifo: a queue-based model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_fc1_weight_fifo;

    localparam int DEPTH = 16;
    localparam int G     = 33;
    localparam int R     = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        fc1_next = 1'b0;
    logic        err_clr = 1'b0;
    logic        wr_ready;
    logic [31:0] w_out;
    logic        w_valid;
    logic [4:0]  level;
    logic [3:0]  row_idx;
    logic [5:0]  grp_idx;
    logic        done;
    logic        overflow;
    logic        underflow;

    fc1_weight_fifo #(.NUM_PE(4), .DEPTH(DEPTH), .GROUPS_PER_ROW(G), .ROWS(R)) dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .fc1_next(fc1_next), .w_out(w_out), .w_valid(w_valid),
        .level(level), .row_idx(row_idx), .grp_idx(grp_idx), .done(done),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] m_wout;
    int          m_row, m_grp;
    bit          m_done, m_ovf, m_udf;
    int          done_seen;
    bit          run_cmp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wout = '0;
        m_row = 0;
        m_grp = 0;
        m_done = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_update(input bit w, input logic [31:0] d, input bit nx,
                                input bit clr, input bit ec);
        int  n;
        bit  pop;
        bit  acc;
        n   = mq.size();
        pop = nx && (n > 0);
        acc = w && ((n < DEPTH) || pop);
        m_ovf = (w && (n == DEPTH) && !pop) || (m_ovf && !ec);
        m_udf = (nx && (n == 0)) || (m_udf && !ec);
        if (clr) begin
            mq.delete();
            m_wout = '0;
            m_row = 0;
            m_grp = 0;
            m_done = 1'b0;
        end else begin
            m_done = pop && (m_row == R - 1) && (m_grp == G - 1);
            if (pop) begin
                void'(mq.pop_front());
                m_grp++;
                if (m_grp == G) begin
                    m_grp = 0;
                    m_row = (m_row + 1) % R;
                end
            end
            if (acc) mq.push_back(d);
            if (mq.size() > 0) m_wout = mq[0];
        end
    endtask

    task automatic step(input bit w, input logic [31:0] d, input bit nx,
                        input bit clr = 1'b0, input bit ec = 1'b0);
        wr_en = w;
        wr_data = d;
        fc1_next = nx;
        clear = clr;
        err_clr = ec;
        @(posedge clk);
        model_update(w, d, nx, clr, ec);
        #1;
        wr_en = 1'b0;
        fc1_next = 1'b0;
        clear = 1'b0;
        err_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_w_valid", 32'(w_valid), 32'(mq.size() > 0));
            chk("m_w_out", w_out, m_wout);
            chk("m_level", 32'(level), 32'(mq.size()));
            chk("m_wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
            chk("m_row_idx", 32'(row_idx), 32'(m_row));
            chk("m_grp_idx", 32'(grp_idx), 32'(m_grp));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_underflow", 32'(underflow), 32'(m_udf));
            if (done) done_seen++;
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_w_out", w_out, 32'h0);
        chk("rst_w_valid", 32'(w_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;

        // 330-group matrix stream: push every cycle, pop from the second cycle on
        done_seen = 0;
        for (int i = 0; i <= 330; i++) begin
            step(i < 330, 32'h9E37_79B9 * 32'(i + 1), i > 0);
            if (i == 32) begin
                chk("pos32_row", 32'(row_idx), 32'd0);
                chk("pos32_grp", 32'(grp_idx), 32'd32);
            end
            if (i == 33) begin
                chk("pos33_row", 32'(row_idx), 32'd1);
                chk("pos33_grp", 32'(grp_idx), 32'd0);
            end
            if (i == 329) begin
                chk("pos329_row", 32'(row_idx), 32'd9);
                chk("pos329_grp", 32'(grp_idx), 32'd32);
                chk("pos329_done", 32'(done), 32'd0);
            end
            if (i == 330) begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_row", 32'(row_idx), 32'd0);
                chk("end_grp", 32'(grp_idx), 32'd0);
                chk("end_level", 32'(level), 32'd0);
            end
        end
        step(1'b0, '0, 1'b0);
        chk("done_after", 32'(done), 32'd0);
        chk("done_once", 32'(done_seen), 32'd1);

        // Three pushes, three pops
        step(1'b1, 32'h0403_0201, 1'b0);
        chk("p1_valid", 32'(w_valid), 32'd1);
        chk("p1_w_out", w_out, 32'h0403_0201);
        step(1'b1, 32'h0807_0605, 1'b0);
        step(1'b1, 32'hFCFD_FEFF, 1'b0);
        chk("p3_level", 32'(level), 32'd3);
        step(1'b0, '0, 1'b1);
        chk("pop1_w_out", w_out, 32'h0807_0605);
        step(1'b0, '0, 1'b1);
        chk("pop2_w_out", w_out, 32'hFCFD_FEFF);
        chk("pop2_pe0", 32'($signed(w_out[7:0])), 32'hFFFF_FFFF);
        chk("pop2_pe3", 32'($signed(w_out[31:24])), 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b1);
        chk("pop3_valid", 32'(w_valid), 32'd0);
        chk("pop3_level", 32'(level), 32'd0);
        chk("pop3_keep", w_out, 32'hFCFD_FEFF);

        // Fill to DEPTH, overflow, then push+pop at full across the RAM wrap
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 15) begin
                chk("full_level", 32'(level), 32'd16);
                chk("full_ready", 32'(wr_ready), 32'd0);
            end
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_head", w_out, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h200 + 32'(i), 1'b1);
            chk("fullpp_level", 32'(level), 32'd16);
        end
        chk("fullpp_head", w_out, 32'h104);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        chk("drain_tail", w_out, 32'h203);
        chk("drain_level", 32'(level), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Underflow and err_clr set-wins
        step(1'b0, '0, 1'b1);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_level", 32'(level), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("udf_clr", 32'(underflow), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("udf_setwins", 32'(underflow), 32'd1);

        // Head-only push+pop
        step(1'b1, 32'hAAAA_0001, 1'b0);
        step(1'b1, 32'hBBBB_0002, 1'b1);
        chk("l1_w_out", w_out, 32'hBBBB_0002);
        chk("l1_valid", 32'(w_valid), 32'd1);
        chk("l1_level", 32'(level), 32'd1);
        step(1'b0, '0, 1'b1);

        // Clear keeps the sticky flag; a push in the clear cycle is dropped
        for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("pre_clr_head", w_out, 32'h302);
        step(1'b1, 32'h3FF, 1'b0, 1'b1);
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(w_valid), 32'd0);
        chk("clr_w_out", w_out, 32'h0);
        chk("clr_grp", 32'(grp_idx), 32'd0);
        chk("clr_row", 32'(row_idx), 32'd0);
        chk("clr_udf", 32'(underflow), 32'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        run_cmp = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_w_out", w_out, 32'h0);
        chk("arst_valid", 32'(w_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        chk("arst_grp", 32'(grp_idx), 32'd0);
        chk("arst_udf", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_cmp = 1'b1;
        step(1'b1, 32'h5555_AAAA, 1'b0);
        chk("post_rst_head", w_out, 32'h5555_AAAA);
        chk("post_rst_level", 32'(level), 32'd1);
        step(1'b0, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc1_weight_fifo.md
Name: fc1_weight_fifo

Overview:
Weight-streaming buffer between the host bus write decoder and the fcn block's fc1 weight input. The host pushes 32-bit words, each holding NUM_PE signed int8 weights. The block presents the head word to fcn as a parallel weight group and advances one group per fc1_next pulse. It also tracks the (row, group) position within the fc1 weight matrix and pulses done after the last group.

Parameters:
NUM_PE, 4, weights per group; NUM_PE*8 must equal 32 (elaboration error otherwise)
DEPTH, 16, total word capacity including the head register; power of two, >= 2
GROUPS_PER_ROW, 33, weight groups per fc1 neuron (132 inputs / 4)
ROWS, 10, fc1 output neurons

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush of data and position counters
wr_en  in  1  host push request
wr_data  in  32  byte k = weight for PE k; [7:0] -> PE0, [31:24] -> PE3
wr_ready  out  1  high when level < DEPTH
fc1_next  in  1  consume pulse from fcn
w_out  out  NUM_PE x 8 signed  head weight group, registered
w_valid  out  1  w_out holds an unconsumed group
level  out  $clog2(DEPTH+1)  words held, head included
row_idx  out  $clog2(ROWS)  neuron index of the head group
grp_idx  out  $clog2(GROUPS_PER_ROW)  group index within the row of the head group
done  out  1  one-cycle pulse on consumption of group (ROWS-1, GROUPS_PER_ROW-1)
overflow  out  1  sticky: push dropped while full
underflow  out  1  sticky: fc1_next while w_valid=0
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset: all outputs 0 (w_out all-zero, wr_ready=1, level=0); pointers and counters 0. Reset mid-stream discards all data and counters immediately.
- Storage: head register (w_out/w_valid) plus a circular RAM of DEPTH-1 entries with wrap-around read and write pointers.
- Priority per edge: clear > normal operation. err_clr is independent of clear.
- Push accepted = wr_en && (level<DEPTH || pop), where pop = fc1_next && w_valid.
- Push into an empty block, or a push coinciding with a pop that leaves the RAM empty: the word loads directly into the head. w_valid=1 on the edge after wr_en is sampled. Latency is 1 cycle.
- Otherwise an accepted push writes the RAM at the write pointer.
- Pop with RAM non-empty: head reloads from the RAM read pointer on the same edge, and w_valid stays 1.
- Pop with RAM empty and no push: w_valid goes to 0. w_out keeps its last value.
- level: +1 on push-only, -1 on pop-only, unchanged on push+pop. Never exceeds DEPTH.
- Full (level==DEPTH): wr_en without pop is dropped and overflow is set. wr_en with pop is accepted and level stays DEPTH. wr_ready is combinational from level only.
- fc1_next with w_valid=0: no state change except underflow is set.
- Position counters advance only on pop.
  - grp_idx increments.
  - At GROUPS_PER_ROW-1, grp_idx wraps to 0 and row_idx increments.
  - At (ROWS-1, GROUPS_PER_ROW-1), both wrap to 0 and done pulses for one cycle on the following cycle.
- clear: head and RAM emptied, w_valid=0, w_out=0, level=0, row_idx/grp_idx=0, done=0. A push in the same cycle is ignored. overflow/underflow are retained.
- err_clr: clears both sticky flags. If an error event occurs in the same cycle, the flag is set (set wins).
- Arithmetic: weights are passed through bit-exact and never sign-altered. Counters are unsigned and wrap only as specified.

Test Plan:
- Push 0x04030201, 0x08070605, 0xFCFDFEFF on consecutive cycles, no fc1_next.
  - Cycle after the first push: w_valid=1, w_out={1,2,3,4}.
  - Level ends at 3.
  - Three pops yield {5,6,7,8} then {-1,-2,-3,-4}, then w_valid=0 and level=0.
- Push 17 words with DEPTH=16.
  - 16 accepted; wr_ready=0 at level 16.
  - 17th push dropped with overflow=1 and contents unchanged.
  - Pushing again with fc1_next at the same time is accepted, level stays 16, and FIFO order is preserved across the RAM wrap.
- fc1_next while empty -> underflow=1 and level stays 0.
  - err_clr -> underflow=0.
  - err_clr coinciding with another empty fc1_next -> underflow stays 1.
- Stream 330 words with interleaved pops.
  - row_idx/grp_idx step 0/0 ... 0/32, 1/0 ... 9/32.
  - done is high exactly once, one cycle after the 330th pop; counters return to 0/0.
- Level 1 (head only), push and fc1_next in the same cycle -> new word appears in the head, w_valid stays 1, level=1.
- After 5 pushes and 2 pops:
  - Assert clear -> level=0, w_valid=0, counters 0, flags unchanged.
  - Then assert rst asynchronously mid-stream -> all outputs read 0 (wr_ready=1) before the next clk edge.
